tiny_host_loader: RTL

Host-side loader/unloader sitting directly upstream of the `tiny` Tate-pairing core. It accepts four GF(3^97) operands as a stream of narrow words and writes them into the core's operand RAM. It then releases the core and waits for `done`. Finally it reads the six result elements back and streams them out as narrow words. The core's 194-bit elements use 2 bits per trit; this block owns the core's `sel/addr/w/data` port and its `reset` (hold) input.

---
 rtl/tiny_host_loader.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/tiny_host_loader.sv
// tiny_host_loader: host-side loader/unloader for the tiny Tate-pairing core.
// It assembles four GF(3^97) operands from narrow input words and writes them into
// the core's operand RAM at slots 3, 5, 6 and 7. It then releases the core and waits
// for done. Finally it reads result slots 9..14 back and streams them out as narrow words.
// Optional build macro: TINY_HOST_CHECK_EN enables invalid-trit (2'b11) detection on
// input words, reported on err. Without it, err is tied low.
module tiny_host_loader #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              busy,
  output logic              err,
  output logic              core_hold,
  output logic              core_sel,
  output logic              core_w,
  output logic [5:0]        core_addr,
  output logic [197:0]      core_data,
  input  logic [197:0]      core_out,
  input  logic              core_done
);

  localparam int ELEM_W = 194;
  localparam int CORE_W = 198;
  localparam int NWORDS = (ELEM_W + WORD_W - 1) / WORD_W;
  localparam int ASM_W  = NWORDS * WORD_W;
  localparam int WCNT_W = $clog2(NWORDS);

  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NWORDS - 1);
  localparam logic [CORE_W-1:0] LIVE_MASK = {{(CORE_W - ELEM_W){1'b0}}, {ELEM_W{1'b1}}};
  localparam logic [2:0]        LAST_WSLOT = 3'd3;
  localparam logic [2:0]        LAST_RSLOT = 3'd5;
  localparam logic [5:0]        RBASE      = 6'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_RUN,
    S_RADDR,
    S_RCAP,
    S_STREAM
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ASM_W-1:0]    r_asm;
  logic [ASM_W-1:0]    r_out;
  logic [WCNT_W-1:0]   r_wcnt;
  logic [2:0]          r_slot;
  logic                r_runSeen;
  logic                w_inFire;
  logic                w_outFire;
  logic                w_lastWord;
  logic                w_badWord;
  logic                w_errHold;
  logic [5:0]          w_writeAddr;

  // Handshakes are derived from the state only, so the output logic never feeds back on itself.
  assign w_inFire   = in_valid  && (r_state == S_LOAD);
  assign w_outFire  = out_ready && (r_state == S_STREAM);
  assign w_lastWord = (r_wcnt == LAST_WORD);

  // Operand slot order in the core RAM: xp, yp, xq, yq.
  always_comb begin
    w_writeAddr = 6'd7;
    case (r_slot)
      3'd0:    w_writeAddr = 6'd3;
      3'd1:    w_writeAddr = 6'd5;
      3'd2:    w_writeAddr = 6'd6;
      default: w_writeAddr = 6'd7;
    endcase
  end

`ifdef TINY_HOST_CHECK_EN
  logic r_err;

  // Flag an accepted word whose live trit positions contain the unused code 2'b11.
  always_comb begin
    w_badWord = 1'b0;
    for (int p = 0; p < WORD_W / 2; p++) begin
      if ((int'(r_wcnt) * WORD_W + 2 * p) < ELEM_W) begin
        if (in_data[2*p +: 2] == 2'b11) begin
          w_badWord = 1'b1;
        end
      end
    end
  end

  // Sticky error flag; once set, only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_inFire && w_badWord) begin
      r_err <= 1'b1;
    end
  end

  assign w_errHold = r_err;
`else
  assign w_badWord = 1'b0;
  assign w_errHold = 1'b0;
`endif

  assign err = w_errHold;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and output decode; a tripped error parks the loader in IDLE with the core held.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    busy      = 1'b1;
    core_hold = 1'b1;
    core_sel  = 1'b0;
    core_w    = 1'b0;
    core_addr = '0;
    core_data = '0;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (!w_errHold) begin
          w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (w_inFire) begin
          if (w_badWord) begin
            w_next = S_IDLE;
          end else if (w_lastWord) begin
            w_next = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        core_sel  = 1'b1;
        core_w    = 1'b1;
        core_addr = w_writeAddr;
        core_data = {{(CORE_W - ELEM_W){1'b0}}, r_asm[ELEM_W-1:0]};
        w_next    = (r_slot == LAST_WSLOT) ? S_RUN : S_LOAD;
      end
      S_RUN: begin
        core_hold = 1'b0;
        if (r_runSeen && core_done) begin
          w_next = S_RADDR;
        end
      end
      S_RADDR: begin
        core_hold = 1'b0;
        core_sel  = 1'b1;
        core_addr = RBASE + {3'b000, r_slot};
        w_next    = S_RCAP;
      end
      S_RCAP: begin
        core_hold = 1'b0;
        w_next    = S_STREAM;
      end
      S_STREAM: begin
        core_hold = 1'b0;
        out_valid = 1'b1;
        out_data  = r_out[WORD_W-1:0];
        if (w_outFire && w_lastWord) begin
          w_next = (r_slot == LAST_RSLOT) ? S_IDLE : S_RADDR;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath: input assembly, word/slot counters, stale-done mask and output shifter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_asm     <= '0;
      r_out     <= '0;
      r_wcnt    <= '0;
      r_slot    <= '0;
      r_runSeen <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_wcnt    <= '0;
          r_slot    <= '0;
          r_runSeen <= 1'b0;
        end
        S_LOAD: begin
          if (w_inFire) begin
            r_asm  <= {in_data, r_asm[ASM_W-1:WORD_W]};
            r_wcnt <= w_lastWord ? '0 : r_wcnt + WCNT_W'(1);
          end
        end
        S_WRITE: begin
          r_slot    <= (r_slot == LAST_WSLOT) ? 3'd0 : r_slot + 3'd1;
          r_runSeen <= 1'b0;
        end
        S_RUN: begin
          r_runSeen <= 1'b1;
        end
        S_RADDR: begin
          r_wcnt <= '0;
        end
        S_RCAP: begin
          r_out <= ASM_W'(core_out & LIVE_MASK);
        end
        S_STREAM: begin
          if (w_outFire) begin
            r_out <= {{WORD_W{1'b0}}, r_out[ASM_W-1:WORD_W]};
            if (w_lastWord) begin
              r_wcnt <= '0;
              r_slot <= (r_slot == LAST_RSLOT) ? 3'd0 : r_slot + 3'd1;
            end else begin
              r_wcnt <= r_wcnt + WCNT_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
